// File: rtl/z2_cycle_seq.sv
// z2_cycle_seq: Zorro II target-side bus cycle sequencer.
// Synchronises the raw 68000 strobes into MEMCLK and tracks one bus cycle at a
// time: it latches the decoded channel, waits for a data strobe, then either
// acknowledges (DTACK), aborts on AS_n release, or raises a bus error on timeout.
//
// Ports:
//   MEMCLK, RESET_n          clock (rising edge), asynchronous active-low reset
//   AS_n, UDS_n, LDS_n, RW   raw bus strobes, asynchronous to MEMCLK
//   ch_hit                   per-channel address-decode hit (combinational)
//   ch_ready                 per-channel completion, sampled only in DATA
//   as_s, uds_s, lds_s, rw_s final synchroniser stage of each strobe
//   z2_state                 current state code (IDLE=0 .. TMO=4)
//   ch_sel                   one-hot channel latched for the current cycle
//   ovr_oe, dtack_oe, berr_oe drive enables for OVR_n, DTACK_n, BERR_n
//   timeout_flag             sticky timeout indicator, cleared only by reset
module z2_cycle_seq #(
  parameter int unsigned       NUM_CH         = 5,
  parameter int unsigned       SYNC_STAGES    = 2,
  parameter logic [NUM_CH-1:0] IMM_MASK       = NUM_CH'(5'b10001),
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              MEMCLK,
  input  logic              RESET_n,
  input  logic              AS_n,
  input  logic              UDS_n,
  input  logic              LDS_n,
  input  logic              RW,
  input  logic [NUM_CH-1:0] ch_hit,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              as_s,
  output logic              uds_s,
  output logic              lds_s,
  output logic              rw_s,
  output logic [2:0]        z2_state,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              ovr_oe,
  output logic              dtack_oe,
  output logic              berr_oe,
  output logic              timeout_flag
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StEnd   = 3'd3,
    StTmo   = 3'd4
  } state_e;

  localparam bit         TmoEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  // Strobe synchronisers; index 0 = AS_n, 1 = UDS_n, 2 = LDS_n, 3 = RW.
  logic [3:0]                  bus_raw;
  logic [3:0][SYNC_STAGES-1:0] sync_q;

  assign bus_raw = {RW, LDS_n, UDS_n, AS_n};

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q <= '1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus_raw[i]};
      end
    end
  end

  assign as_s  = sync_q[0][SYNC_STAGES-1];
  assign uds_s = sync_q[1][SYNC_STAGES-1];
  assign lds_s = sync_q[2][SYNC_STAGES-1];
  assign rw_s  = sync_q[3][SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              dtack_q, dtack_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tflag_q, tflag_d;
  logic [NUM_CH-1:0] hit_low;
  logic              ack;

  // Two's-complement trick isolates the lowest set bit of ch_hit.
  assign hit_low = ch_hit & (~ch_hit + NUM_CH'(1));
  assign ack     = |(sel_q & (IMM_MASK | ch_ready));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dtack_d = dtack_q;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    case (state_q)
      StIdle: begin
        if (!as_s && (|ch_hit)) begin
          state_d = StStart;
          sel_d   = hit_low;
        end
      end
      StStart: begin
        if (as_s) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if (!uds_s || !lds_s) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
        // Abort beats acknowledge; acknowledge beats timeout on the same edge.
        if (as_s) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if (ack) begin
          state_d = StEnd;
          dtack_d = 1'b1;
        end else if (TmoEn && (cnt_q == TmoLast)) begin
          state_d = StTmo;
          tflag_d = 1'b1;
        end
      end
      StEnd: begin
        if (as_s) begin
          state_d = StIdle;
          sel_d   = '0;
          dtack_d = 1'b0;
        end
      end
      StTmo: begin
        if (as_s) begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
        dtack_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      dtack_q <= 1'b0;
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dtack_q <= dtack_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign z2_state     = state_q;
  assign ch_sel       = sel_q;
  assign timeout_flag = tflag_q;

  // Drive enables follow the raw AS_n so the bus is released without sync delay.
  assign ovr_oe   = RESET_n & ~AS_n & (|ch_hit);
  assign dtack_oe = dtack_q & ovr_oe;
  assign berr_oe  = (state_q == StTmo) & ~AS_n;

endmodule

// File: tb/tb_z2_cycle_seq.sv
// tb_z2_cycle_seq: self-checking bench for z2_cycle_seq (NUM_CH=5, SYNC_STAGES=2,
// IMM_MASK=5'b10001, TIMEOUT_CYCLES=8). Each step drives one cycle of inputs,
// queues the expected post-edge outputs and compares them after the edge.
module tb_z2_cycle_seq;

  localparam logic       L  = 1'b0;
  localparam logic       H  = 1'b1;
  localparam logic [2:0] SI = 3'd0;
  localparam logic [2:0] SS = 3'd1;
  localparam logic [2:0] SD = 3'd2;
  localparam logic [2:0] SE = 3'd3;
  localparam logic [2:0] ST = 3'd4;
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] C0 = 5'b00001;
  localparam logic [4:0] C1 = 5'b00010;
  localparam logic [4:0] C2 = 5'b00100;

  typedef struct {
    logic       as_n, uds_n, lds_n, rw;
    logic [4:0] hit, rdy;
    logic [2:0] st;
    logic [4:0] sel;
    logic       dt, ovr, berr, tf, as_s;
  } vec_t;

  logic       MEMCLK = 1'b0;
  logic       RESET_n;
  logic       AS_n, UDS_n, LDS_n, RW;
  logic [4:0] ch_hit, ch_ready;
  logic       as_s, uds_s, lds_s, rw_s;
  logic [2:0] z2_state;
  logic [4:0] ch_sel;
  logic       ovr_oe, dtack_oe, berr_oe, timeout_flag;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t t031[9];

  z2_cycle_seq #(
    .NUM_CH        (5),
    .SYNC_STAGES   (2),
    .IMM_MASK      (5'b10001),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .MEMCLK      (MEMCLK),
    .RESET_n     (RESET_n),
    .AS_n        (AS_n),
    .UDS_n       (UDS_n),
    .LDS_n       (LDS_n),
    .RW          (RW),
    .ch_hit      (ch_hit),
    .ch_ready    (ch_ready),
    .as_s        (as_s),
    .uds_s       (uds_s),
    .lds_s       (lds_s),
    .rw_s        (rw_s),
    .z2_state    (z2_state),
    .ch_sel      (ch_sel),
    .ovr_oe      (ovr_oe),
    .dtack_oe    (dtack_oe),
    .berr_oe     (berr_oe),
    .timeout_flag(timeout_flag)
  );

  always #5 MEMCLK = ~MEMCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(logic as_n, logic uds_n, logic lds_n, logic rw,
                              logic [4:0] hit, logic [4:0] rdy, logic [2:0] st,
                              logic [4:0] sel, logic dt, logic ovr, logic berr,
                              logic tf, logic as_sv);
    vec_t v;
    v.as_n = as_n; v.uds_n = uds_n; v.lds_n = lds_n; v.rw = rw;
    v.hit = hit; v.rdy = rdy; v.st = st; v.sel = sel;
    v.dt = dt; v.ovr = ovr; v.berr = berr; v.tf = tf; v.as_s = as_sv;
    return v;
  endfunction

  function automatic void chk(string name, logic [7:0] act, logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic compare_front(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".z2_state"},     8'(z2_state),     8'(e.st));
      chk({name, ".ch_sel"},       8'(ch_sel),       8'(e.sel));
      chk({name, ".dtack_oe"},     8'(dtack_oe),     8'(e.dt));
      chk({name, ".ovr_oe"},       8'(ovr_oe),       8'(e.ovr));
      chk({name, ".berr_oe"},      8'(berr_oe),      8'(e.berr));
      chk({name, ".timeout_flag"}, 8'(timeout_flag), 8'(e.tf));
      chk({name, ".as_s"},         8'(as_s),         8'(e.as_s));
    end
  endtask

  // Drive one cycle at the falling edge, compare 1 ns after the rising edge.
  task automatic step(input vec_t v, input string name);
    @(negedge MEMCLK);
    AS_n = v.as_n; UDS_n = v.uds_n; LDS_n = v.lds_n; RW = v.rw;
    ch_hit = v.hit; ch_ready = v.rdy;
    exp_q.push_back(v);
    @(posedge MEMCLK);
    #1;
    compare_front(name);
  endtask

  task automatic idle(input logic tf);
    step(mk(H, H, H, H, Z, Z, SI, Z, L, L, L, tf, H), "idle");
  endtask

  initial begin
    vec_t v;
    // Immediate-ack read on ch0; AS_n released after two END cycles.
    t031[0] = mk(L, H, H, H, C0, Z, SI, Z,  L, H, L, L, H);
    t031[1] = mk(L, L, H, H, C0, Z, SI, Z,  L, H, L, L, L);
    t031[2] = mk(L, L, H, H, C0, Z, SS, C0, L, H, L, L, L);
    t031[3] = mk(L, L, H, H, C0, Z, SD, C0, L, H, L, L, L);
    t031[4] = mk(L, L, H, H, C0, Z, SE, C0, H, H, L, L, L);
    t031[5] = mk(L, L, H, H, C0, Z, SE, C0, H, H, L, L, L);
    t031[6] = mk(H, H, H, H, C0, Z, SE, C0, L, L, L, L, L);
    t031[7] = mk(H, H, H, H, C0, Z, SE, C0, L, L, L, L, H);
    t031[8] = mk(H, H, H, H, C0, Z, SI, Z,  L, L, L, L, H);

    RESET_n = 1'b0;
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    ch_hit = '0; ch_ready = '0;
    repeat (2) @(posedge MEMCLK);
    #1;
    exp_q.push_back(mk(H, H, H, H, Z, Z, SI, Z, L, L, L, L, H));
    compare_front("reset");
    chk("reset.uds_s", 8'(uds_s), 8'(1));
    chk("reset.lds_s", 8'(lds_s), 8'(1));
    chk("reset.rw_s",  8'(rw_s),  8'(1));
    RESET_n = 1'b1;
    idle(L);
    idle(L);

    for (int i = 0; i < 9; i++) step(t031[i], $sformatf("imm_read[%0d]", i));
    idle(L);

    // Abort while in START (no data strobe yet).
    step(mk(L, H, H, H, C0, Z, SI, Z,  L, H, L, L, H), "abort_start0");
    step(mk(L, H, H, H, C0, Z, SI, Z,  L, H, L, L, L), "abort_start1");
    step(mk(L, H, H, H, C0, Z, SS, C0, L, H, L, L, L), "abort_start2");
    step(mk(H, H, H, H, C0, Z, SS, C0, L, L, L, L, L), "abort_start3");
    step(mk(H, H, H, H, C0, Z, SS, C0, L, L, L, L, H), "abort_start4");
    step(mk(H, H, H, H, C0, Z, SI, Z,  L, L, L, L, H), "abort_start5");
    idle(L);

    // Abort while in DATA on a non-immediate channel.
    step(mk(L, L, H, H, C1, Z, SI, Z,  L, H, L, L, H), "abort_data0");
    step(mk(L, L, H, H, C1, Z, SI, Z,  L, H, L, L, L), "abort_data1");
    step(mk(L, L, H, H, C1, Z, SS, C1, L, H, L, L, L), "abort_data2");
    step(mk(L, L, H, H, C1, Z, SD, C1, L, H, L, L, L), "abort_data3");
    step(mk(H, H, H, H, C1, Z, SD, C1, L, L, L, L, L), "abort_data4");
    step(mk(H, H, H, H, C1, Z, SD, C1, L, L, L, L, H), "abort_data5");
    step(mk(H, H, H, H, C1, Z, SI, Z,  L, L, L, L, H), "abort_data6");
    idle(L);

    // Lowest hit wins; later ch_hit changes, foreign ready bits and ready
    // outside DATA are ignored; END one edge after ch_ready[1].
    step(mk(L, L, H, H, 5'b00110, Z, SI, Z, L, H, L, L, H), "wait_ch1_0");
    step(mk(L, L, H, H, 5'b00110, Z, SI, Z, L, H, L, L, L), "wait_ch1_1");
    step(mk(L, L, H, H, 5'b00110, Z, SS, C1, L, H, L, L, L), "wait_ch1_2");
    step(mk(L, L, H, H, 5'b00110, C1, SD, C1, L, H, L, L, L), "wait_ch1_3");
    for (int i = 0; i < 5; i++) begin
      step(mk(L, L, H, H, C0, 5'b00101, SD, C1, L, H, L, L, L), "wait_ch1_dwell");
    end
    step(mk(L, L, H, H, C0, C1, SE, C1, H, H, L, L, L), "wait_ch1_end");
    step(mk(H, H, H, H, C0, Z,  SE, C1, L, L, L, L, L), "wait_ch1_rel0");
    step(mk(H, H, H, H, C0, Z,  SE, C1, L, L, L, L, H), "wait_ch1_rel1");
    step(mk(H, H, H, H, C0, Z,  SI, Z,  L, L, L, L, H), "wait_ch1_rel2");
    idle(L);

    // Ready arrives on the very edge the timeout would fire: acknowledge wins.
    step(mk(L, L, H, H, C2, Z, SI, Z,  L, H, L, L, H), "ack_vs_tmo0");
    step(mk(L, L, H, H, C2, Z, SI, Z,  L, H, L, L, L), "ack_vs_tmo1");
    step(mk(L, L, H, H, C2, Z, SS, C2, L, H, L, L, L), "ack_vs_tmo2");
    for (int i = 0; i < 8; i++) begin
      step(mk(L, L, H, H, C2, Z, SD, C2, L, H, L, L, L), "ack_vs_tmo_dwell");
    end
    step(mk(L, L, H, H, C2, C2, SE, C2, H, H, L, L, L), "ack_vs_tmo_end");
    step(mk(H, H, H, H, C2, Z,  SE, C2, L, L, L, L, L), "ack_vs_tmo_rel0");
    step(mk(H, H, H, H, C2, Z,  SE, C2, L, L, L, L, H), "ack_vs_tmo_rel1");
    step(mk(H, H, H, H, C2, Z,  SI, Z,  L, L, L, L, H), "ack_vs_tmo_rel2");
    idle(L);

    // Write via LDS_n on ch2 with no ready: TMO after 8 DATA cycles.
    step(mk(L, H, L, L, C2, Z, SI, Z,  L, H, L, L, H), "tmo0");
    step(mk(L, H, L, L, C2, Z, SI, Z,  L, H, L, L, L), "tmo1");
    chk("tmo1.rw_s", 8'(rw_s), 8'(0));
    step(mk(L, H, L, L, C2, Z, SS, C2, L, H, L, L, L), "tmo2");
    for (int i = 0; i < 8; i++) begin
      step(mk(L, H, L, L, C2, Z, SD, C2, L, H, L, L, L), "tmo_dwell");
    end
    step(mk(L, H, L, L, C2, Z, ST, C2, L, H, H, H, L), "tmo_enter");
    step(mk(L, H, L, L, C2, Z, ST, C2, L, H, H, H, L), "tmo_hold");
    step(mk(H, H, H, H, C2, Z, ST, C2, L, L, L, H, L), "tmo_rel0");
    step(mk(H, H, H, H, C2, Z, ST, C2, L, L, L, H, H), "tmo_rel1");
    step(mk(H, H, H, H, C2, Z, SI, Z,  L, L, L, H, H), "tmo_rel2");
    idle(H);

    // Reset during END, then restart with AS_n still low.
    for (int i = 0; i < 5; i++) begin
      v = t031[i];
      v.tf = H;
      step(v, $sformatf("rst_pre[%0d]", i));
    end
    RESET_n = 1'b0;
    #1;
    exp_q.push_back(mk(L, L, H, H, C0, Z, SI, Z, L, L, L, L, H));
    compare_front("rst_async");
    step(mk(L, L, H, H, C0, Z, SI, Z, L, L, L, L, H), "rst_held");
    RESET_n = 1'b1;
    for (int i = 0; i < 9; i++) step(t031[i], $sformatf("rst_post[%0d]", i));
    idle(L);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
